// File: rtl/int2fp_conv_pkg.sv
// Shared FP encoding definitions: field widths, packed single-precision
// layout and the converter state encoding.
package int2fp_conv_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  // Exponent of a magnitude whose leading one sits in bit 31.
  localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_BIAS + 31);

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } conv_state_t;

endpackage

// File: rtl/int2fp_conv_if.sv
// Start/busy/done handshake and operand/result bus of the converter.
interface int2fp_conv_if;

  logic        start;
  logic [31:0] int_in;
  logic        is_signed;
  logic        busy;
  logic        done;
  logic [31:0] fp_result;
  logic        inexact;

  modport master (
    output start, int_in, is_signed,
    input  busy, done, fp_result, inexact
  );

  modport slave (
    input  start, int_in, is_signed,
    output busy, done, fp_result, inexact
  );

endinterface

// File: rtl/int2fp_conv_round.sv
// Round-to-nearest-even of a normalised 32-bit magnitude (leading one in
// bit 31) down to a 23-bit stored mantissa. Purely combinational.
module fp_round_rne
  import int2fp_conv_pkg::*;
(
  input  logic [31:0]          i_mag,
  input  logic [FP_EXP_W-1:0]  i_exp,
  output logic [FP_EXP_W-1:0]  o_exp,
  output logic [FP_MANT_W-1:0] o_mant,
  output logic                 o_inexact
);

  logic w_lsb;
  logic w_guard;
  logic w_sticky;
  logic w_round_up;
  logic w_carry;

  assign w_lsb      = i_mag[8];
  assign w_guard    = i_mag[7];
  assign w_sticky   = |i_mag[6:0];
  assign w_round_up = w_guard & (w_sticky | w_lsb);

  // An all-ones significand rolls over to the next binade: the stored
  // mantissa wraps to zero on its own and the exponent absorbs the carry.
  assign w_carry    = w_round_up & (&i_mag[31:8]);

  assign o_mant     = i_mag[30:8] + FP_MANT_W'(w_round_up);
  assign o_exp      = i_exp + FP_EXP_W'(w_carry);
  assign o_inexact  = w_guard | w_sticky;

endmodule

// File: rtl/int2fp_conv.sv
// Sequential 32-bit integer to IEEE-754 single converter. Captures the
// operand on start, left-normalises it up to NORM_STEP bits per cycle,
// rounds to nearest-even and presents a registered packed result.
module int2fp_conv
  import int2fp_conv_pkg::*;
#(
  parameter int NORM_STEP = 1   // legal: 1, 2, 4, 8
) (
  input  logic          clk,
  input  logic          n_rst,
  int2fp_conv_if.slave  bus
);

  conv_state_t         r_state;
  logic                r_sgn;
  logic [31:0]         r_mag;
  logic [FP_EXP_W-1:0] r_exp;
  logic                r_busy;
  logic                r_done;
  logic                r_inexact;
  fp32_t               r_result;

  logic                 w_in_sgn;
  logic                 w_top_zero;
  logic [FP_EXP_W-1:0]  w_rnd_exp;
  logic [FP_MANT_W-1:0] w_rnd_mant;
  logic                 w_rnd_inexact;

  assign w_in_sgn   = bus.is_signed & bus.int_in[31];
  // A wide shift is only safe when it cannot push a set bit out of the top.
  assign w_top_zero = (r_mag[31 -: NORM_STEP] == '0);

  fp_round_rne u_round (
    .i_mag     (r_mag),
    .i_exp     (r_exp),
    .o_exp     (w_rnd_exp),
    .o_mant    (w_rnd_mant),
    .o_inexact (w_rnd_inexact)
  );

  // Converter FSM with datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // values from before the edge, independent of statement order.
    if (!n_rst) begin
      r_state   <= IDLE;
      r_sgn     <= 1'b0;
      r_mag     <= '0;
      r_exp     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_inexact <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // -2^31 negates to itself, which is the correct magnitude.
            r_sgn   <= w_in_sgn;
            r_mag   <= w_in_sgn ? (~bus.int_in + 32'd1) : bus.int_in;
            r_exp   <= EXP_INIT;
            r_busy  <= 1'b1;
            r_state <= NORM;
          end
        end
        NORM: begin
          if (r_mag == '0) begin
            // Zero has no leading one; emit +0 regardless of input sign.
            r_result  <= '0;
            r_inexact <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (r_mag[31]) begin
            r_state <= ROUND;
          end else if (w_top_zero) begin
            r_mag <= r_mag << NORM_STEP;
            r_exp <= r_exp - FP_EXP_W'(NORM_STEP);
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - FP_EXP_W'(1);
          end
        end
        ROUND: begin
          r_result  <= '{sign: r_sgn, exp: w_rnd_exp, mant: w_rnd_mant};
          r_inexact <= w_rnd_inexact;
          r_done    <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fp_result = r_result;
  assign bus.inexact   = r_inexact;

endmodule

// File: tb/tb_int2fp_conv.sv
// Self-checking bench for int2fp_conv: a cycle-level behavioural model of
// the handshake and an arithmetic reference of the conversion, compared
// against the DUT every cycle, plus directed literal vectors.
module tb_int2fp_conv;

  localparam int NS = 1;

  logic clk;
  logic n_rst;
  int   n_total;
  int   n_pass;
  bit   mon_en;

  int2fp_conv_if bus();

  int2fp_conv #(.NORM_STEP(NS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference conversion: locate the leading one, shift right to 24
  // significant bits and round the discarded remainder against one half.
  function automatic void ref_conv(input logic [31:0] v, input logic sgnd,
                                   output logic [31:0] fp, output logic inx,
                                   output int lat);
    logic sgn;
    longint unsigned mag, q, rem, half;
    int p, e, sh, lz, s;
    sgn = sgnd & v[31];
    mag = sgn ? ((64'd1 << 32) - {32'd0, v}) : {32'd0, v};
    if (mag == 0) begin
      fp = 32'd0; inx = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 0) p = i;
    e   = 127 + p;
    rem = 0;
    if (p <= 23) q = mag << (23 - p);
    else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q & 64'd1) != 0)) q = q + 1;
    end
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    fp  = {sgn, 8'(e), 23'(q)};
    inx = (rem != 0);
    lz = 31 - p; s = 0;
    while (lz >= NS) begin lz = lz - NS; s++; end
    s   = s + lz;
    lat = 2 + s;
  endfunction

  // Handshake model: m_pos counts edges since acceptance, -1 when idle.
  int          m_pos = -1;
  int          m_lat = 0;
  logic [31:0] m_fp = '0, m_nfp = '0;
  logic        m_inx = 1'b0, m_ninx = 1'b0;
  int          m_dones = 0;

  always @(posedge clk) begin
    if (!n_rst) begin
      m_pos = -1; m_fp = '0; m_inx = 1'b0;
    end else if (m_pos < 0) begin
      if (bus.start === 1'b1) begin
        m_pos = 0;
        ref_conv(bus.int_in, bus.is_signed, m_nfp, m_ninx, m_lat);
      end
    end else begin
      m_pos++;
      if (m_pos == m_lat) begin
        m_fp = m_nfp; m_inx = m_ninx; m_dones++;
      end else if (m_pos == m_lat + 1) m_pos = -1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy",      32'(bus.busy),    32'(m_pos >= 0));
      check("done",      32'(bus.done),    32'(m_pos >= 0 && m_pos == m_lat));
      check("fp_result", bus.fp_result,    m_fp);
      check("inexact",   32'(bus.inexact), 32'(m_inx));
    end
  end

  task automatic pin_model(input string name, input logic [31:0] v, input logic sg,
                           input logic [31:0] efp, input logic einx, input int elat);
    logic [31:0] fp; logic inx; int lat;
    ref_conv(v, sg, fp, inx, lat);
    check({name, "_model_fp"},  fp,       efp);
    check({name, "_model_inx"}, 32'(inx), 32'(einx));
    check({name, "_model_lat"}, lat,      elat);
  endtask

  task automatic convert(input string name, input logic [31:0] v, input logic sg,
                         input logic [31:0] efp, input logic einx, input int elat);
    int  k;
    bit  seen;
    k = 0;
    while (bus.busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    bus.start = 1'b1; bus.int_in = v; bus.is_signed = sg;
    @(negedge clk);
    bus.start = 1'b0; bus.int_in = $urandom; bus.is_signed = 1'($urandom);
    seen = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (i > 1) begin bus.int_in = $urandom; bus.is_signed = 1'($urandom); end
      if (bus.done === 1'b1) begin
        seen = 1;
        check({name, "_lat"}, i,                elat);
        check({name, "_fp"},  bus.fp_result,    efp);
        check({name, "_inx"}, 32'(bus.inexact), 32'(einx));
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [8];
    sp = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF,
           32'h7FFFFFFF, 32'h01000001, 32'h01000003, 32'h00FFFFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return sp[$urandom_range(0, 7)];
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    int d, d0;
    n_total = 0; n_pass = 0; mon_en = 0;
    bus.start = 1'b0; bus.int_in = '0; bus.is_signed = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1; mon_en = 1;
    check("rst_busy", 32'(bus.busy),    32'd0);
    check("rst_done", 32'(bus.done),    32'd0);
    check("rst_fp",   bus.fp_result,    32'd0);
    check("rst_inx",  32'(bus.inexact), 32'd0);

    pin_model("one",    32'h00000001, 1'b0, 32'h3F800000, 1'b0, 33);
    pin_model("neg1",   32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 33);
    pin_model("min",    32'h80000000, 1'b1, 32'hCF000000, 1'b0, 2);
    pin_model("umax",   32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 2);
    pin_model("tie_ev", 32'h01000001, 1'b0, 32'h4B800000, 1'b1, 9);
    pin_model("tie_od", 32'h01000003, 1'b0, 32'h4B800002, 1'b1, 9);
    pin_model("zero",   32'h00000000, 1'b1, 32'h00000000, 1'b0, 1);

    convert("one",    32'h00000001, 1'b0, 32'h3F800000, 1'b0, 33);
    convert("neg1",   32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 33);
    convert("min",    32'h80000000, 1'b1, 32'hCF000000, 1'b0, 2);
    convert("umax",   32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 2);
    convert("tie_ev", 32'h01000001, 1'b0, 32'h4B800000, 1'b1, 9);
    convert("tie_od", 32'h01000003, 1'b0, 32'h4B800002, 1'b1, 9);
    convert("zero",   32'h00000000, 1'b1, 32'h00000000, 1'b0, 1);

    // start held high with a changing operand: one done per acceptance.
    d = 0; d0 = m_dones;
    bus.start = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bus.int_in = rand_operand(); bus.is_signed = 1'($urandom);
      @(negedge clk);
      if (bus.done === 1'b1) d++;
    end
    bus.start = 1'b0;
    check("held_done_count", d, m_dones - d0);
    check("held_multi", 32'(d >= 3), 32'd1);

    // Reset for one edge in the middle of NORM.
    while (bus.busy !== 1'b0) @(negedge clk);
    bus.start = 1'b1; bus.int_in = 32'h1; bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check("midrst_busy", 32'(bus.busy),    32'd0);
    check("midrst_done", 32'(bus.done),    32'd0);
    check("midrst_fp",   bus.fp_result,    32'd0);
    check("midrst_inx",  32'(bus.inexact), 32'd0);
    d = 0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1) d++; end
    check("midrst_no_done", d, 0);
    convert("after_rst", 32'h00001234, 1'b0, 32'h4591A000, 1'b0, 21);

    // Random traffic, including occasional resets, checked by the model.
    for (int i = 0; i < 4000; i++) begin
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.int_in    = rand_operand();
      bus.is_signed = 1'($urandom);
      n_rst         = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    n_rst = 1'b1; bus.start = 1'b0;
    repeat (50) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
